keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//   Drives a 4x4 matrix keypad row by row, samples the columns, and debounces the result.
//   Produces the 16-bit one-hot key vector consumed by the keypad-to-digit encoder.
//   Bit index = 4*row + col. Example: key "0" = bit 3 (row 0, col 3); key "7" = bit 15.
//   Sits between the keypad pins and the digit encoder/display path.
// PARAMETERS
//   SCAN_DIV        4   clk cycles per row slot; must be >= 4 (covers 2-flop sync + settling)
//   DEBOUNCE_SCANS  3   consecutive identical full frames needed to commit press or release; >= 1
// PORTS
//   clk        in   1   system clock, all logic on posedge
//   rst_n      in   1   asynchronous active-low reset
//   col_n      in   4   keypad columns, active low, externally pulled up, asynchronous
//   row_n      out  4   row drive, active low, exactly one row low at a time
//   onehot     out  16  committed key, one-hot; 16'h0000 when no key committed
//   key_valid  out  1   high while a key is committed (state PRESSED or RELEASE_PEND)
//   key_press  out  1   1-cycle pulse on each new committed press
// BEHAVIOUR
//   Reset (async, rst_n=0):
//   - row_n=4'b1110, div_cnt=0, row=0, frame=0, state=IDLE
//   - onehot=0, key_valid=0, key_press=0, col sync flops=4'b1111
//   Scan:
//   - col_n passes through a 2-flop synchronizer -> col_s.
//   - div_cnt counts 0..SCAN_DIV-1. At div_cnt==SCAN_DIV-1: frame[4*row+:4] <= ~col_s, then row advances (3 wraps to 0).
//   - row_n = ~(4'b0001<<row), registered. Frame period = 4*SCAN_DIV cycles.
//   - Frame-done strobe fires on the cycle row 3 is sampled. The FSM evaluates the completed frame on the next cycle (1-cycle latency).
//   Frame class: NONE = 0 bits set, ONE = exactly 1 bit set, MULTI = 2 or more bits set (ghosting, never committed).
//   FSM (advances only on frame evaluation; cnt saturates at DEBOUNCE_SCANS):
//   - IDLE:
//       ONE -> cand=frame, cnt=1; if DEBOUNCE_SCANS==1 commit, else -> PRESS_PEND.
//       NONE/MULTI -> stay.
//   - PRESS_PEND:
//       ONE and frame==cand -> cnt++; at cnt==DEBOUNCE_SCANS commit.
//       ONE and frame!=cand -> cand=frame, cnt=1.
//       NONE/MULTI -> IDLE.
//   - commit: onehot<=cand, key_valid<=1, key_press<=1 for one cycle -> PRESSED.
//   - PRESSED:
//       NONE -> cnt=1; if DEBOUNCE_SCANS==1 release, else -> RELEASE_PEND.
//       Any other frame -> stay. No rollover: a second key is ignored until all keys are released.
//   - RELEASE_PEND:
//       NONE -> cnt++; at cnt==DEBOUNCE_SCANS release.
//       Any other frame -> PRESSED.
//   - release: onehot<=0, key_valid<=0 -> IDLE. No pulse on release.
//   Output guarantees:
//   - onehot is always 0 or exactly one bit; it changes only at commit or release.
//   - key_press never pulses twice for one physical press.
//   - rst_n asserted mid-scan or mid-debounce returns everything to reset values at once.
//     After release of rst_n, scanning restarts at row 0 with a fresh frame.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3; cycle 0 = first posedge after rst_n rises)
//   1 Idle scan: no key pressed -> row_n cycles 1110,1101,1011,0111 every 4 cycles; onehot=0; key_press never pulses.
//   2 Key "5" (row 2, col 2) held from reset -> one key_press pulse near cycle 48; onehot=16'h0400 and key_valid=1 while held.
//   3 Bounce: key "0" toggled every 8 cycles for 64 cycles, then held -> no commit during bouncing;
//     commit (onehot=16'h0008) 3 frames after it becomes stable.
//   4 Release: from test 2, release the key -> onehot=0 and key_valid=0 about 3 frames (~48 cycles) later; no pulse on release.
//   5 Ghosting: keys "1"+"2" pressed together from IDLE -> no commit.
//     Key "9" pressed while "7" is committed -> onehot stays 16'h8000 until all keys are released.
//   6 Reset mid-debounce: rst_n pulsed low in PRESS_PEND -> all outputs go to reset values immediately;
//     a held key recommits 3 frames after reset is released.

Source files
------------

// File: rtl/keypad_if.sv
// Pin-side and key-side signals of the 4x4 keypad scanner.
`timescale 1ns/1ps
interface keypad_if;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_press;

    modport master (
        input  col_n,
        output row_n,
        output onehot,
        output key_valid,
        output key_press
    );

    modport slave (
        output col_n,
        input  row_n,
        input  onehot,
        input  key_valid,
        input  key_press
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with frame-level debounce.
// Emits a one-hot committed key (bit = 4*row + col) and a press pulse.
`timescale 1ns/1ps
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input logic      clk,
    input logic      rst_n,
    keypad_if.master kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    logic [3:0]    sync1_q;
    logic [3:0]    col_s_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [1:0]    row_q;
    logic [1:0]    row_d;
    logic [3:0]    row_n_q;
    logic [15:0]   frame_q;
    logic          done_q;
    logic          slot_end;

    state_t        state_q;
    logic [15:0]   cand_q;
    logic [15:0]   onehot_q;
    logic [CW-1:0] cnt_q;
    logic          valid_q;
    logic          press_q;
    logic          none;
    logic          one;

    assign slot_end = (div_q == DIV_LAST);
    assign div_d    = slot_end ? '0 : div_q + 1'b1;
    assign row_d    = row_q + 2'd1;
    assign none     = (frame_q == '0);
    assign one      = !none && ((frame_q & (frame_q - 16'd1)) == '0);

    // Columns are sampled at the end of each row slot, after sync and settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            col_s_q <= 4'hF;
            div_q   <= '0;
            row_q   <= '0;
            row_n_q <= 4'b1110;
            frame_q <= '0;
            done_q  <= 1'b0;
        end else begin
            sync1_q <= kp.col_n;
            col_s_q <= sync1_q;
            div_q   <= div_d;
            done_q  <= slot_end && (row_q == 2'd3);
            if (slot_end) begin
                frame_q[4*row_q +: 4] <= ~col_s_q;
                row_q   <= row_d;
                row_n_q <= ~(4'b0001 << row_d);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cand_q   <= '0;
            cnt_q    <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            press_q <= 1'b0;
            if (done_q) begin
                unique case (state_q)
                    IDLE: begin
                        if (one) begin
                            cand_q <= frame_q;
                            cnt_q  <= CNT_ONE;
                            if (DEBOUNCE_SCANS == 1) begin
                                onehot_q <= frame_q;
                                valid_q  <= 1'b1;
                                press_q  <= 1'b1;
                                state_q  <= PRESSED;
                            end else begin
                                state_q <= PRESS_PEND;
                            end
                        end
                    end
                    PRESS_PEND: begin
                        if (!one) begin
                            state_q <= IDLE;
                        end else if (frame_q != cand_q) begin
                            cand_q <= frame_q;
                            cnt_q  <= CNT_ONE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CNT_LAST) begin
                                onehot_q <= cand_q;
                                valid_q  <= 1'b1;
                                press_q  <= 1'b1;
                                state_q  <= PRESSED;
                            end
                        end
                    end
                    PRESSED: begin
                        // Ghost or second key while held: ignored, no rollover.
                        if (none) begin
                            cnt_q <= CNT_ONE;
                            if (DEBOUNCE_SCANS == 1) begin
                                onehot_q <= '0;
                                valid_q  <= 1'b0;
                                state_q  <= IDLE;
                            end else begin
                                state_q <= RELEASE_PEND;
                            end
                        end
                    end
                    RELEASE_PEND: begin
                        if (!none) begin
                            state_q <= PRESSED;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == CNT_LAST) begin
                                onehot_q <= '0;
                                valid_q  <= 1'b0;
                                state_q  <= IDLE;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign kp.row_n     = row_n_q;
    assign kp.onehot    = onehot_q;
    assign kp.key_valid = valid_q;
    assign kp.key_press = press_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a frame-level reference model.
`timescale 1ns/1ps
module tb_keypad_scanner;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0] cn;
    int total = 0;
    int bad = 0;

    keypad_if kp();

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kp(kp)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its column to its row when that row is low.
    always_comb begin
        cn = 4'hF;
        for (int r = 0; r < 4; r++)
            if (!kp.row_n[r]) cn = cn & ~keys[4*r +: 4];
    end
    assign kp.col_n = cn;

    // Reference model: rows are seen 2 cycles into their slot, a frame every 16 cycles,
    // commit after 3 identical single-key frames, release after 3 empty frames.
    int n = 0;
    logic [15:0] mfr = '0;
    logic [15:0] mkey = '0;
    logic mval = 1'b0;
    logic mpress = 1'b0;
    logic [3:0] mrow_n = 4'b1110;
    logic [15:0] hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            mfr = '0;
            mkey = '0;
            mval = 1'b0;
            mpress = 1'b0;
            mrow_n = 4'b1110;
            hist.delete();
        end else begin
            int e;
            int r;
            e = n;
            mpress = 1'b0;
            if (e > 0 && e % 16 == 0) begin
                hist.push_back(mfr);
                if (hist.size() > 3) void'(hist.pop_front());
                if (hist.size() == 3) begin
                    if (mval) begin
                        if (hist[0] == 0 && hist[1] == 0 && hist[2] == 0) begin
                            mval = 1'b0;
                            mkey = '0;
                        end
                    end else if (hist[0] == hist[1] && hist[1] == hist[2]
                                 && $countones(hist[0]) == 1) begin
                        mval = 1'b1;
                        mkey = hist[0];
                        mpress = 1'b1;
                    end
                end
            end
            if (e % 4 == 1) begin
                r = (e / 4) % 4;
                mfr[4*r +: 4] = keys[4*r +: 4];
            end
            mrow_n = ~(4'b0001 << (((e + 1) / 4) % 4));
            n = n + 1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    int pulses = 0;
    int press_edge = -1;

    always @(negedge clk) begin
        chk("row_n", {12'h0, kp.row_n}, {12'h0, mrow_n});
        chk("onehot", kp.onehot, mkey);
        chk("key_valid", {15'h0, kp.key_valid}, {15'h0, mval});
        chk("key_press", {15'h0, kp.key_press}, {15'h0, mpress});
        if (rst_n && kp.key_press === 1'b1) begin
            pulses++;
            press_edge = n - 1;
        end
    end

    task automatic tick(input int c);
        repeat (c) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        press_edge = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int k;
        #1;
        keys = '0;
        do_reset();
        chk("rst_row_n", {12'h0, kp.row_n}, 16'h000E);
        chk("rst_onehot", kp.onehot, 16'h0000);

        // Idle scan
        tick(64);
        chk("idle_pulses", 16'(pulses), 16'd0);
        chk("idle_onehot", kp.onehot, 16'h0000);

        // Key "5" held from reset
        keys = 16'h0400;
        do_reset();
        tick(80);
        chk("k5_edge", 16'(press_edge), 16'd48);
        chk("k5_onehot", kp.onehot, 16'h0400);
        chk("k5_valid", {15'h0, kp.key_valid}, 16'h0001);
        chk("k5_pulses", 16'(pulses), 16'd1);

        // Release
        keys = '0;
        tick(64);
        chk("rel_onehot", kp.onehot, 16'h0000);
        chk("rel_valid", {15'h0, kp.key_valid}, 16'h0000);
        chk("rel_pulses", 16'(pulses), 16'd1);

        // Bounce on key "0", 8-cycle toggles, then held
        k = 0;
        while (n % 16 != 2 && k < 20) begin
            tick(1);
            k++;
        end
        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            keys = (i % 2 == 0) ? 16'h0008 : 16'h0000;
            tick(8);
        end
        chk("bnc_pulses", 16'(pulses - p0), 16'd0);
        chk("bnc_onehot", kp.onehot, 16'h0000);
        keys = 16'h0008;
        tick(80);
        chk("bnc_commit", kp.onehot, 16'h0008);
        chk("bnc_pulse1", 16'(pulses - p0), 16'd1);
        keys = '0;
        tick(80);

        // Ghosting and no rollover
        p0 = pulses;
        keys = 16'h0003;
        tick(96);
        chk("ghost_onehot", kp.onehot, 16'h0000);
        chk("ghost_pulses", 16'(pulses - p0), 16'd0);
        keys = '0;
        tick(32);
        keys = 16'h8000;
        tick(80);
        chk("k7_onehot", kp.onehot, 16'h8000);
        keys = 16'h8200;
        tick(80);
        chk("k7k9_onehot", kp.onehot, 16'h8000);
        keys = 16'h0200;
        tick(80);
        chk("k9only_onehot", kp.onehot, 16'h8000);
        keys = '0;
        tick(80);
        chk("allrel_onehot", kp.onehot, 16'h0000);
        chk("roll_pulses", 16'(pulses - p0), 16'd1);

        // Reset in PRESS_PEND, key held throughout
        keys = 16'h1000;
        do_reset();
        tick(36);
        chk("pp_valid", {15'h0, kp.key_valid}, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_row_n", {12'h0, kp.row_n}, 16'h000E);
        chk("mid_rst_onehot", kp.onehot, 16'h0000);
        chk("mid_rst_press", {15'h0, kp.key_press}, 16'h0000);
        tick(3);
        rst_n = 1'b1;
        press_edge = -1;
        tick(64);
        chk("rerun_edge", 16'(press_edge), 16'd48);
        chk("rerun_onehot", kp.onehot, 16'h1000);
        keys = '0;
        tick(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
